// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings and burst-length helper for the bus arbiter.
package ahb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'b00,
    HR_ERROR = 2'b01,
    HR_RETRY = 2'b10,
    HR_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Beats in a burst; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_beats(input hburst_t burst);
    case (burst)
      HB_SINGLE:           return 5'd1;
      HB_INCR:             return 5'd0;
      HB_WRAP4, HB_INCR4:  return 5'd4;
      HB_WRAP8, HB_INCR8:  return 5'd8;
      HB_WRAP16, HB_INCR16: return 5'd16;
      default:             return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signal bundle between the bus masters/mux and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  import ahb_bus_arbiter_pkg::*;

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  htrans_t                HTRANS;
  hburst_t                HBURST;
  logic                   HREADY;
  hresp_t                 HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

endinterface

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester after last_i, wrapping,
// with last_i itself checked last and DEFAULT_MASTER when nobody requests.
module ahb_bus_arbiter_rr_picker #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MW-1:0]          last_i,
  output logic [NUM_MASTERS-1:0] grant_oh_o,
  output logic [MW-1:0]          grant_idx_o
);

  function automatic logic [MW-1:0] wrap_add(input logic [MW-1:0] base, input int step);
    logic [MW:0] sum;
    sum = {1'b0, base} + (MW+1)'(step);
    if (sum >= (MW+1)'(NUM_MASTERS)) begin
      sum = sum - (MW+1)'(NUM_MASTERS);
    end else begin
      sum = sum;
    end
    return sum[MW-1:0];
  endfunction

  // Scan farthest-first so the nearest requester after last_i overrides.
  always_comb begin
    grant_idx_o = MW'(DEFAULT_MASTER);
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (req_i[wrap_add(last_i, k)]) begin
        grant_idx_o = wrap_add(last_i, k);
      end else begin
        grant_idx_o = grant_idx_o;
      end
    end
  end

  assign grant_oh_o = NUM_MASTERS'(1) << grant_idx_o;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with unsplittable fixed bursts and
// locked sequences; HGRANT/HMASTER/HMASTLOCK are all registered.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state_d, state_q;
  logic [3:0]             cnt_d, cnt_q;
  logic [NUM_MASTERS-1:0] gnt_d, gnt_q;
  logic [MW-1:0]          gnt_idx_d, gnt_idx_q;
  logic [MW-1:0]          hmaster_d, hmaster_q;
  logic                   hmastlock_d, hmastlock_q;
  logic [NUM_MASTERS-1:0] pick_oh_s;
  logic [MW-1:0]          pick_idx_s;
  logic [4:0]             beats_s;
  logic                   fixed_burst_s;
  logic                   owner_locks_s;

  ahb_bus_arbiter_rr_picker #(
    .NUM_MASTERS    (NUM_MASTERS),
    .DEFAULT_MASTER (DEFAULT_MASTER)
  ) u_picker (
    .req_i       (bus.HBUSREQ),
    .last_i      (hmaster_q),
    .grant_oh_o  (pick_oh_s),
    .grant_idx_o (pick_idx_s)
  );

  // Next-state: arbitration, burst/lock tracking and address-phase owner.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    beats_s       = burst_beats(bus.HBURST);
    fixed_burst_s = (bus.HTRANS == HT_NONSEQ) && (beats_s >= 5'd4);
    owner_locks_s = bus.HLOCK[gnt_idx_q] && bus.HBUSREQ[gnt_idx_q];

    if (bus.HREADY) begin
      hmaster_d   = gnt_idx_q;
      hmastlock_d = bus.HLOCK[gnt_idx_q];
    end else begin
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
    end

    case (state_q)
      ST_ARB: begin
        if (!bus.HREADY) begin
          state_d = ST_ARB;
        end else if (owner_locks_s) begin
          state_d = ST_LOCKED;
          cnt_d   = 4'd0;
        end else if (fixed_burst_s) begin
          // Grant is held so the burst starting now is not split.
          state_d = ST_BURST;
          cnt_d   = 4'(beats_s - 5'd1);
        end else begin
          gnt_d     = pick_oh_s;
          gnt_idx_d = pick_idx_s;
        end
      end
      ST_BURST: begin
        if (bus.HRESP != HR_OKAY) begin
          state_d = ST_ARB;
          cnt_d   = 4'd0;
        end else if (!bus.HREADY) begin
          cnt_d = cnt_q;
        end else if ((bus.HTRANS == HT_IDLE) || (bus.HTRANS == HT_NONSEQ)) begin
          state_d = ST_ARB;
          cnt_d   = 4'd0;
        end else if (bus.HTRANS == HT_SEQ) begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_ARB;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_LOCKED: begin
        if (bus.HREADY && !bus.HLOCK[gnt_idx_q]) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_ARB;
      cnt_q       <= 4'd0;
      gnt_q       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      gnt_idx_q   <= MW'(DEFAULT_MASTER);
      hmaster_q   <= MW'(DEFAULT_MASTER);
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.HGRANT    = gnt_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic HCLK = 1'b0;
  logic HRESETn;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: who is granted, who owns the address phase, beats still to come.
  int m_grant;
  int m_owner;
  int m_beats;
  bit m_mlock;
  bit m_locked;
  int blen [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return DEF;
  endfunction

  task automatic model_edge();
    int g;
    int prev_owner;
    g = m_grant;
    prev_owner = m_owner;
    if (!HRESETn) begin
      m_grant = DEF; m_owner = DEF; m_mlock = 1'b0; m_locked = 1'b0; m_beats = 0;
      return;
    end
    if (bus.HREADY) begin
      m_owner = g;
      m_mlock = bus.HLOCK[g];
    end
    if (m_locked) begin
      if (bus.HREADY && !bus.HLOCK[g]) m_locked = 1'b0;
    end else if (m_beats > 0) begin
      if (bus.HRESP != HR_OKAY) m_beats = 0;
      else if (bus.HREADY && (bus.HTRANS inside {HT_IDLE, HT_NONSEQ})) m_beats = 0;
      else if (bus.HREADY && bus.HTRANS == HT_SEQ) m_beats = m_beats - 1;
    end else if (bus.HREADY) begin
      if (bus.HLOCK[g] && bus.HBUSREQ[g]) m_locked = 1'b1;
      else if (bus.HTRANS == HT_NONSEQ && blen[int'(bus.HBURST)] >= 4)
        m_beats = blen[int'(bus.HBURST)] - 1;
      else m_grant = rr_pick(prev_owner, bus.HBUSREQ);
    end
  endtask

  task automatic step(input logic rstn, input logic [N-1:0] req, input logic [N-1:0] lock,
                      input htrans_t tr, input hburst_t bu, input logic rdy, input hresp_t rs);
    HRESETn     = rstn;
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    bus.HRESP   = rs;
    @(posedge HCLK);
    model_edge();
    #1;
    check_val("hgrant", int'(bus.HGRANT), 1 << m_grant);
    check_val("grant_onehot", $countones(bus.HGRANT), 1);
    check_val("hmaster", int'(bus.HMASTER), m_owner);
    check_val("hmastlock", int'(bus.HMASTLOCK), int'(m_mlock));
  endtask

  logic [N-1:0] rq;
  logic [N-1:0] lk;
  int           tsel;
  htrans_t      tr_r;

  initial begin
    m_grant = DEF; m_owner = DEF; m_mlock = 1'b0; m_locked = 1'b0; m_beats = 0;

    // Reset
    step(1'b0, 4'b0000, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    step(1'b0, 4'b0000, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    check_val("reset_hgrant", int'(bus.HGRANT), 1);
    check_val("reset_hmaster", int'(bus.HMASTER), 0);
    check_val("reset_hmastlock", int'(bus.HMASTLOCK), 0);

    // Round-robin between M1 and M2 with single transfers
    for (int i = 0; i < 6; i++)
      step(1'b1, 4'b0110, 4'b0000, HT_NONSEQ, HB_SINGLE, 1'b1, HR_OKAY);

    // Lock by M3 while M0 also requests
    step(1'b0, 4'b0000, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b1001, 4'b1000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    check_val("lock_hgrant", int'(bus.HGRANT), 8);
    check_val("lock_hmastlock", int'(bus.HMASTLOCK), 1);
    for (int i = 0; i < 2; i++)
      step(1'b1, 4'b1001, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    check_val("unlock_hgrant", int'(bus.HGRANT), 1);

    // M1 INCR8 aborted by ERROR on beat 3, M2 waiting
    step(1'b0, 4'b0000, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    step(1'b1, 4'b0010, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    step(1'b1, 4'b0010, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    step(1'b1, 4'b0110, 4'b0000, HT_NONSEQ, HB_INCR8, 1'b1, HR_OKAY);
    step(1'b1, 4'b0110, 4'b0000, HT_SEQ, HB_INCR8, 1'b1, HR_OKAY);
    check_val("burst_hold_hgrant", int'(bus.HGRANT), 2);
    step(1'b1, 4'b0110, 4'b0000, HT_SEQ, HB_INCR8, 1'b1, HR_OKAY);
    step(1'b1, 4'b0110, 4'b0000, HT_SEQ, HB_INCR8, 1'b0, HR_ERROR);
    check_val("err_hold_hgrant", int'(bus.HGRANT), 2);
    step(1'b1, 4'b0110, 4'b0000, HT_IDLE, HB_INCR8, 1'b1, HR_ERROR);
    check_val("err_regrant", int'(bus.HGRANT), 4);

    // Wait states at an arbitration point freeze the outputs
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b0, HR_OKAY);
    check_val("wait_hgrant", int'(bus.HGRANT), 4);
    check_val("wait_hmaster", int'(bus.HMASTER), 1);
    step(1'b1, 4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1, HR_OKAY);
    check_val("wait_release_hmaster", int'(bus.HMASTER), 2);

    // Randomized traffic with sticky lock requests and occasional resets
    lk = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom);
      if ($urandom_range(0, 7) == 0) lk = N'($urandom);
      tsel = int'($urandom_range(0, 9));
      if (tsel < 5)      tr_r = HT_SEQ;
      else if (tsel < 6) tr_r = HT_BUSY;
      else if (tsel < 8) tr_r = HT_NONSEQ;
      else               tr_r = HT_IDLE;
      step(($urandom_range(0, 199) != 0), rq, lk, tr_r,
           hburst_t'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) == 0) ? hresp_t'($urandom_range(1, 3)) : HR_OKAY);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
